// File: rtl/gf180mcu_fd_sc_mcu9t5v0__dlymeas_pkg.sv
// rtl/gf180mcu_fd_sc_mcu9t5v0__dlymeas_pkg.sv - shared state encoding and defaults for the delay-measurement controller
package gf180mcu_fd_sc_mcu9t5v0__dlymeas_pkg;

    localparam int CNT_W_DEF       = 8;
    localparam int SYNC_STAGES_DEF = 2;

    // S_ prefix keeps the DONE state distinct from the DONE port
    typedef enum logic [2:0] {
        S_IDLE,
        S_ARM,
        S_RISE,
        S_FALL,
        S_DONE
    } state_t;

endpackage

// File: rtl/gf180mcu_fd_sc_mcu9t5v0__dlymeas_sync.sv
// rtl/gf180mcu_fd_sc_mcu9t5v0__dlymeas_sync.sv - flop-chain synchronizer for the returning chain edge
module gf180mcu_fd_sc_mcu9t5v0__dlymeas_sync
    import gf180mcu_fd_sc_mcu9t5v0__dlymeas_pkg::*;
#(
    parameter int SYNC_STAGES = SYNC_STAGES_DEF
) (
    input  logic CLK,
    input  logic RN,
    input  logic D,
    output logic Q
);

    logic [SYNC_STAGES-1:0] r_sync;

    always_ff @(posedge CLK) begin
        if (!RN) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], D};
        end
    end

    assign Q = r_sync[SYNC_STAGES-1];

endmodule

// File: rtl/gf180mcu_fd_sc_mcu9t5v0__dlymeas.sv
// rtl/gf180mcu_fd_sc_mcu9t5v0__dlymeas.sv - launch/capture FSM with saturating round-trip cycle counter
module gf180mcu_fd_sc_mcu9t5v0__dlymeas
    import gf180mcu_fd_sc_mcu9t5v0__dlymeas_pkg::*;
#(
    parameter int CNT_W       = CNT_W_DEF,
    parameter int SYNC_STAGES = SYNC_STAGES_DEF
) (
    input  logic             CLK,
    input  logic             RN,
    input  logic             START,
    input  logic             RET,
    output logic             LAUNCH,
    output logic             BUSY,
    output logic             DONE,
    output logic             TIMEOUT,
    output logic [CNT_W-1:0] COUNT
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] r_count;
    logic             r_launch;
    logic             r_busy;
    logic             r_done;
    logic             r_timeout;
    logic             w_rs;
    logic [CNT_W-1:0] w_cnt_inc;
    logic             w_cnt_hit;

    gf180mcu_fd_sc_mcu9t5v0__dlymeas_sync #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_ret_sync (
        .CLK (CLK),
        .RN  (RN),
        .D   (RET),
        .Q   (w_rs)
    );

    // Timeout fires on the increment that lands on all-ones, so the counter never wraps
    assign w_cnt_inc = (r_cnt == CNT_MAX) ? CNT_MAX : r_cnt + CNT_ONE;
    assign w_cnt_hit = (w_cnt_inc == CNT_MAX);

    always_ff @(posedge CLK) begin
        if (!RN) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_count   <= '0;
            r_launch  <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_timeout <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (START) begin
                        r_cnt     <= '0;
                        r_count   <= '0;
                        r_timeout <= 1'b0;
                        r_busy    <= 1'b1;
                        r_state   <= S_ARM;
                    end
                end
                S_ARM: begin
                    if (!w_rs) begin
                        r_cnt    <= '0;
                        r_launch <= 1'b1;
                        r_state  <= S_RISE;
                    end else begin
                        r_cnt <= w_cnt_inc;
                        if (w_cnt_hit) begin
                            r_timeout <= 1'b1;
                            r_state   <= S_FALL;
                        end
                    end
                end
                S_RISE: begin
                    if (w_rs) begin
                        r_count  <= r_cnt;
                        r_launch <= 1'b0;
                        r_state  <= S_FALL;
                    end else begin
                        r_cnt <= w_cnt_inc;
                        if (w_cnt_hit) begin
                            r_count   <= CNT_MAX;
                            r_timeout <= 1'b1;
                            r_launch  <= 1'b0;
                            r_state   <= S_FALL;
                        end
                    end
                end
                // Chain must drain before reuse; a stuck-high chain parks here until reset
                S_FALL: begin
                    if (!w_rs) begin
                        r_done  <= 1'b1;
                        r_state <= S_DONE;
                    end
                end
                S_DONE: begin
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign LAUNCH  = r_launch;
    assign BUSY    = r_busy;
    assign DONE    = r_done;
    assign TIMEOUT = r_timeout;
    assign COUNT   = r_count;

endmodule

// File: tb/tb_gf180mcu_fd_sc_mcu9t5v0__dlymeas.sv
// tb/tb_gf180mcu_fd_sc_mcu9t5v0__dlymeas.sv - directed bench for the delay-measurement controller
module tb_gf180mcu_fd_sc_mcu9t5v0__dlymeas;

    logic       clk   = 1'b0;
    logic       rn    = 1'b0;
    logic       start = 1'b0;
    logic       ret4  = 1'b0;
    logic       ret8;
    int         mode  = 0;

    logic       launch8, busy8, done8, to8;
    logic [7:0] count8;
    logic       launch4, busy4, done4, to4;
    logic [3:0] count4;

    logic [4:0] pipe_p = '0;
    logic [5:0] pipe_n = '0;

    int n_assert = 0;
    int n_fail   = 0;
    int t_done;

    always #5 clk = ~clk;

    // Delay-chain models: 5 full cycles (posedge pipe) and 5.5 cycles (negedge pipe)
    always @(posedge clk) pipe_p <= {pipe_p[3:0], launch8};
    always @(negedge clk) pipe_n <= {pipe_n[4:0], launch8};

    always_comb begin
        ret8 = launch8;
        if (mode == 1) ret8 = pipe_p[4];
        else if (mode == 2) ret8 = pipe_n[5];
    end

    gf180mcu_fd_sc_mcu9t5v0__dlymeas u_dut8 (
        .CLK     (clk),
        .RN      (rn),
        .START   (start),
        .RET     (ret8),
        .LAUNCH  (launch8),
        .BUSY    (busy8),
        .DONE    (done8),
        .TIMEOUT (to8),
        .COUNT   (count8)
    );

    gf180mcu_fd_sc_mcu9t5v0__dlymeas #(
        .CNT_W (4)
    ) u_dut4 (
        .CLK     (clk),
        .RN      (rn),
        .START   (start),
        .RET     (ret4),
        .LAUNCH  (launch4),
        .BUSY    (busy4),
        .DONE    (done4),
        .TIMEOUT (to4),
        .COUNT   (count4)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_assert++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Pulses START and returns the number of edges after the START edge at which DONE is seen (-1 if never)
    task automatic measure(input bit use4, input int budget, input int restart_at, output int t);
        start = 1'b1;
        tick();
        start = 1'b0;
        t = -1;
        for (int i = 1; i <= budget && t < 0; i++) begin
            if (i == restart_at) start = 1'b1;
            tick();
            start = 1'b0;
            if ((use4 ? done4 : done8) === 1'b1) t = i;
        end
    endtask

    initial begin
        rn = 1'b0;
        idle(2);
        check("rst_launch", launch8, 0);
        check("rst_busy", busy8, 0);
        check("rst_done", done8, 0);
        check("rst_timeout", to8, 0);
        check("rst_count", count8, 0);
        check("rst_count4", count4, 0);
        rn = 1'b1;
        tick();

        mode = 0;
        measure(0, 40, -1, t_done);
        check("loop_done_edge", t_done, 7);
        check("loop_count", count8, 2);
        check("loop_timeout", to8, 0);
        check("loop_busy_at_done", busy8, 1);
        tick();
        check("loop_done_one_cycle", done8, 0);
        check("loop_busy_fall", busy8, 0);
        idle(20);

        mode = 1;
        measure(0, 60, -1, t_done);
        check("d5_done_edge", t_done, 17);
        check("d5_count", count8, 7);
        check("d5_timeout", to8, 0);
        idle(20);

        mode = 2;
        measure(0, 60, -1, t_done);
        check("d55_done_seen", t_done >= 0, 1);
        check("d55_count_7_or_8", (count8 == 8'd7) || (count8 == 8'd8), 1);
        idle(20);

        mode = 1;
        measure(0, 60, 3, t_done);
        check("restart_rise_done_edge", t_done, 17);
        check("restart_rise_count", count8, 7);
        start = 1'b1;
        tick();
        start = 1'b0;
        check("start_at_done_busy", busy8, 0);
        tick();
        check("start_at_done_busy2", busy8, 0);
        check("start_at_done_count", count8, 7);
        idle(20);

        measure(1, 40, -1, t_done);
        check("rise_to_done_edge", t_done, 17);
        check("rise_to_count", count4, 15);
        check("rise_to_timeout", to4, 1);
        check("rise_to_launch", launch4, 0);
        tick();
        check("rise_to_done_fall", done4, 0);
        check("rise_to_busy_fall", busy4, 0);
        check("rise_to_timeout_held", to4, 1);
        start = 1'b1;
        tick();
        start = 1'b0;
        check("restart_clears_timeout", to4, 0);
        check("restart_clears_count", count4, 0);
        check("restart_busy", busy4, 1);
        idle(25);

        ret4 = 1'b1;
        idle(5);
        start = 1'b1;
        tick();
        start = 1'b0;
        idle(14);
        check("arm_to_not_yet", to4, 0);
        tick();
        check("arm_to_timeout", to4, 1);
        check("arm_to_count", count4, 0);
        check("arm_to_launch", launch4, 0);
        idle(10);
        check("arm_stuck_busy", busy4, 1);
        check("arm_stuck_no_done", done4, 0);
        ret4 = 1'b0;
        t_done = -1;
        for (int i = 1; i <= 10 && t_done < 0; i++) begin
            tick();
            if (done4 === 1'b1) t_done = i;
        end
        check("arm_drain_done_edge", t_done, 3);
        check("arm_drain_timeout", to4, 1);
        idle(20);

        mode = 1;
        start = 1'b1;
        tick();
        start = 1'b0;
        idle(4);
        check("mid_launch_high", launch8, 1);
        rn = 1'b0;
        tick();
        check("mid_rst_launch", launch8, 0);
        check("mid_rst_busy", busy8, 0);
        check("mid_rst_count", count8, 0);
        check("mid_rst_done", done8, 0);
        rn = 1'b1;
        idle(20);
        measure(0, 60, -1, t_done);
        check("post_rst_done_edge", t_done, 17);
        check("post_rst_count", count8, 7);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
